// File: rtl/mul_issue_ctrl.sv
// Issue sequencer for the Booth multiplier: buffers operand pairs, runs one
// multiply at a time over start/done, and returns tagged products with a timeout watchdog.
module mul_issue_ctrl #(
   parameter int unsigned WIDTH         = 16,
   parameter int unsigned TAG_W         = 4,
   parameter int unsigned DEPTH         = 2,
   parameter int unsigned CAPTURE_DELAY = 1,
   parameter int unsigned TIMEOUT       = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_multiplicand,
   input  logic [WIDTH-1:0]     in_multiplier,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 out_error,
   output logic                 mul_start,
   output logic [WIDTH-1:0]     mul_multiplicand,
   output logic [WIDTH-1:0]     mul_multiplier,
   input  logic                 mul_done,
   input  logic [2*WIDTH-1:0]   mul_product,
   output logic                 busy
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned PTR_W   = AW + 1;
   localparam int unsigned ENTRY_W = TAG_W + 2 * WIDTH;
   localparam int unsigned WD_W    = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {IDLE, START, WAIT, CAPT, RESP} state_t;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               empty;
   logic               full;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] head;

   state_t             state;
   state_t             state_nxt;
   logic [WD_W-1:0]    wdog;
   logic [TAG_W-1:0]   tag_q;
   logic               resp_load;
   logic               timeout_hit;

   // Extra pointer MSB distinguishes full from empty when the indices match
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign head     = mem[rd_ptr[AW-1:0]];
   assign busy     = !empty || (state != IDLE);

   // FIFO storage needs no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {in_tag, in_multiplicand, in_multiplier};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Next-state and pop/capture decisions
   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      resp_load   = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: state_nxt = WAIT;
         WAIT: begin
            if (mul_done) begin
               if (CAPTURE_DELAY == 0) begin
                  state_nxt = RESP;
                  resp_load = 1'b1;
               end else begin
                  state_nxt = CAPT;
               end
            end else if (wdog == WD_W'(TIMEOUT - 1)) begin
               state_nxt   = RESP;
               resp_load   = 1'b1;
               timeout_hit = 1'b1;
            end
         end
         CAPT: begin
            state_nxt = RESP;
            resp_load = 1'b1;
         end
         RESP: begin
            if (out_ready) begin
               if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         mul_start        <= 1'b0;
         out_valid        <= 1'b0;
         mul_multiplicand <= '0;
         mul_multiplier   <= '0;
         tag_q            <= '0;
         wdog             <= '0;
         out_product      <= '0;
         out_tag          <= '0;
         out_error        <= 1'b0;
      end else begin
         state     <= state_nxt;
         mul_start <= (state_nxt == START);
         out_valid <= (state_nxt == RESP);
         if (pop) {tag_q, mul_multiplicand, mul_multiplier} <= head;
         if (state == START)     wdog <= '0;
         else if (state == WAIT) wdog <= wdog + WD_W'(1);
         // Result registers only change on RESP entry, so they hold under backpressure
         if (resp_load) begin
            out_tag     <= tag_q;
            out_error   <= timeout_hit;
            out_product <= timeout_hit ? '0 : mul_product;
         end
      end
   end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a fixed-latency multiplier model.
module tb_mul_issue_ctrl;

   localparam int LAT = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_multiplicand = '0;
   logic [15:0] in_multiplier = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_product;
   logic [3:0]  out_tag;
   logic        out_error;
   logic        mul_start;
   logic [15:0] mul_multiplicand;
   logic [15:0] mul_multiplier;
   logic        mul_done;
   logic [31:0] mul_product;
   logic        busy;

   logic        model_en = 1'b1;
   logic        force_done = 1'b0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   typedef struct packed {
      logic [3:0]  tag;
      logic [31:0] prod;
      logic        err;
   } exp_t;
   exp_t sb_q[$];

   mul_issue_ctrl #(
      .WIDTH(16), .TAG_W(4), .DEPTH(2), .CAPTURE_DELAY(1), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_multiplicand(in_multiplicand), .in_multiplier(in_multiplier), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_product(out_product), .out_tag(out_tag), .out_error(out_error),
      .mul_start(mul_start), .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
      .mul_done(mul_done), .mul_product(mul_product), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic void fail_timeout(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: event not seen within bound (cycle %0d)", name, cyc);
   endfunction

   // Multiplier model: done LAT cycles after start, product held until the next done
   initial begin
      int          cnt;
      logic [31:0] m_prod;
      cnt = 0;
      m_prod = '0;
      mul_done = 1'b0;
      mul_product = '0;
      forever begin
         @(posedge clk);
         #2;
         mul_done = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               mul_done = 1'b1;
               mul_product = m_prod;
            end
         end
         if (mul_start && model_en) begin
            cnt = LAT;
            m_prod = 32'($signed(mul_multiplicand)) * 32'($signed(mul_multiplier));
         end
         if (force_done) mul_done = 1'b1;
      end
   end

   // Result monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_result: actual tag=%0h product=%0h, required none", out_tag, out_product);
            end else begin
               e = sb_q.pop_front();
               check("sb_tag", 32'(out_tag), 32'(e.tag));
               check("sb_product", out_product, e.prod);
               check("sb_error", 32'(out_error), 32'(e.err));
            end
         end
      end
   end

   task automatic push_req(input logic [3:0] tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] p, input logic e, output int t);
      exp_t x;
      in_valid = 1'b1;
      in_tag = tag;
      in_multiplicand = a;
      in_multiplier = b;
      t = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (in_ready) begin
            t = cyc;
            x.tag = tag;
            x.prod = p;
            x.err = e;
            sb_q.push_back(x);
            break;
         end
      end
      if (t < 0) fail_timeout("push_accept");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // which: 0 start, 1 done, 2 out_valid, 3 output handshake
   task automatic wait_for(input int which, input string name, output int c);
      logic hit;
      c = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         case (which)
            0:       hit = mul_start;
            1:       hit = mul_done;
            2:       hit = out_valid;
            default: hit = out_valid && out_ready;
         endcase
         if (hit) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) fail_timeout(name);
   endtask

   initial begin
      int t, c, s, v, h, bad;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mul_start", 32'(mul_start), 32'd0);
      check("rst_out_product", out_product, 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_out_error", 32'(out_error), 32'd0);
      check("rst_mul_operands", {mul_multiplicand, mul_multiplier}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single operation: 3 * -5
      out_ready = 1'b1;
      push_req(4'h2, 16'h0003, 16'hFFFB, 32'hFFFFFFF1, 1'b0, t);
      wait_for(0, "t1_start", c);
      check("t1_start_latency", 32'(c), 32'(t + 2));
      wait_for(1, "t1_done", s);
      wait_for(2, "t1_valid", v);
      check("t1_valid_latency", 32'(v), 32'(s + 2));
      repeat (3) @(negedge clk);

      // FIFO full with output stalled, then back-to-back drain
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      push_req(4'h3, 16'h0010, 16'h0010, 32'h00000100, 1'b0, t);
      push_req(4'h4, 16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0, t);
      push_req(4'h5, 16'h7FFF, 16'h0002, 32'h0000FFFE, 1'b0, t);
      in_valid = 1'b1;
      in_tag = 4'h6;
      in_multiplicand = 16'h0005;
      in_multiplier = 16'h0005;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("full_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_for(2, "bp_valid", v);
      for (int i = 0; i < 10; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_tag", 32'(out_tag), 32'h3);
         check("bp_out_product", out_product, 32'h00000100);
         check("bp_out_error", 32'(out_error), 32'd0);
         check("bp_no_start", 32'(mul_start), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_for(3, "b2b_handshake", h);
         if (k < 2) begin
            @(negedge clk);
            check("b2b_start", 32'(mul_start), 32'd1);
         end
      end

      // Spurious done while idle
      repeat (2) @(posedge clk);
      #1;
      force_done = 1'b1;
      @(posedge clk);
      #1;
      force_done = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_valid || mul_start || busy) bad++;
      end
      check("idle_spurious_done", 32'(bad), 32'd0);

      // Timeout, then a spurious done while the error response is held
      @(posedge clk);
      #1;
      model_en = 1'b0;
      out_ready = 1'b0;
      push_req(4'h7, 16'h1234, 16'h0010, 32'h00000000, 1'b1, t);
      wait_for(0, "to_start", c);
      wait_for(2, "to_valid", v);
      check("to_valid_latency", 32'(v), 32'(c + 1 + 8));
      check("to_error", 32'(out_error), 32'd1);
      check("to_product", out_product, 32'd0);
      @(posedge clk);
      #1;
      force_done = 1'b1;
      @(posedge clk);
      #1;
      force_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("resp_spur_valid", 32'(out_valid), 32'd1);
         check("resp_spur_error", 32'(out_error), 32'd1);
         check("resp_spur_product", out_product, 32'd0);
         check("resp_spur_tag", 32'(out_tag), 32'h7);
      end
      @(posedge clk);
      #1;
      model_en = 1'b1;
      out_ready = 1'b1;
      push_req(4'h8, 16'h8000, 16'h8000, 32'h40000000, 1'b0, t);
      wait_for(1, "after_to_done", s);
      wait_for(2, "after_to_valid", v);
      check("after_to_latency", 32'(v), 32'(s + 2));
      repeat (3) @(negedge clk);

      // Reset during WAIT with two entries queued
      @(posedge clk);
      #1;
      push_req(4'h9, 16'h0002, 16'h0003, 32'h00000006, 1'b0, t);
      push_req(4'hA, 16'h0004, 16'h0003, 32'h0000000C, 1'b0, t);
      push_req(4'hB, 16'h0005, 16'h0003, 32'h0000000F, 1'b0, t);
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_mul_start", 32'(mul_start), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_operands", {mul_multiplicand, mul_multiplier}, 32'd0);
      check("mid_rst_out_tag", 32'(out_tag), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid || mul_start || busy || !in_ready) bad++;
      end
      check("post_rst_quiet", 32'(bad), 32'd0);

      for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
